// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-channel, W-bit registered channel-merge mux.
// A single output register stage uses a valid/ready handshake. The grant
// comes either from an external select (mode=0) or from a round-robin scan
// that starts at a rotating pointer (mode=1).
// Optional build macro MUX_RR_PARITY_EN adds the registered even-parity
// output f_par.

// Per-channel lane: passes the channel word when granted, zero otherwise,
// so the top can OR-combine all lanes into the selected word.
module mux_nx1_rr_lane #(
    parameter int W = 8
) (
    input  logic [W-1:0] d,
    input  logic         en,
    output logic [W-1:0] q
);

    assign q = en ? d : '0;

endmodule

module mux_nx1_rr #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   x,
    input  logic [N-1:0]     x_valid,
    output logic [N-1:0]     x_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] s,
    output logic [W-1:0]     f,
    output logic [SEL_W-1:0] f_ch,
    output logic             f_valid,
`ifdef MUX_RR_PARITY_EN
    output logic             f_par,
`endif
    input  logic             f_ready
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("mux_nx1_rr: N must be in 2..16");
    end

    logic                 ld;       // output stage can take a beat this cycle
    logic [SEL_W-1:0]     ptr;      // round-robin scan start
    logic                 fix_vld;
    logic                 rr_vld;
    logic [SEL_W-1:0]     rr_gnt;
    logic                 gnt_vld;
    logic [SEL_W-1:0]     gnt;
    logic [N-1:0]         gnt_oh;
    logic                 xfer;
    logic [N-1:0][W-1:0]  lane_q;
    logic [W-1:0]         gnt_data;

    assign ld = !f_valid || f_ready;

    // Fixed select: s only grants when it names an existing, valid channel.
    // Comparing against each index keeps s>=N from indexing out of range.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (s == SEL_W'(i) && x_valid[i])
                fix_vld = 1'b1;
        end
    end

    // Round-robin scan: the first valid channel at ptr, ptr+1, ... wins.
    // The wrap is modulo N. The loop runs from the far end back to ptr, so
    // the closest hit is the one written last.
    always_comb begin
        int j;
        j      = 0;
        rr_vld = 1'b0;
        rr_gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N)
                j = j - N;
            if (x_valid[j]) begin
                rr_vld = 1'b1;
                rr_gnt = SEL_W'(j);
            end
        end
    end

    // Mode picks the grant source.
    always_comb begin
        gnt_vld = mode ? rr_vld : fix_vld;
        gnt     = mode ? rr_gnt : s;
    end

    // One-hot grant vector; it drives both the lane enables and x_ready.
    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < N; i++)
            gnt_oh[i] = gnt_vld && (gnt == SEL_W'(i));
    end

    // x_ready is held low during reset and whenever the output stage is stalled.
    assign x_ready = (ld && !rst) ? gnt_oh : '0;
    assign xfer    = gnt_vld && ld;

    for (genvar g = 0; g < N; g++) begin : g_lane
        mux_nx1_rr_lane #(.W(W)) u_lane (
            .d  (x[g*W +: W]),
            .en (gnt_oh[g]),
            .q  (lane_q[g])
        );
    end

    // OR-combine the gated lanes into the granted word.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++)
            gnt_data = gnt_data | lane_q[i];
    end

    // The scan pointer moves past the winner only on round-robin transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (xfer && mode)
            ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
    end

    // Output stage: load on transfer, drain on pop, and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f       <= '0;
            f_ch    <= '0;
            f_valid <= 1'b0;
        end else if (xfer) begin
            f       <= gnt_data;
            f_ch    <= gnt;
            f_valid <= 1'b1;
        end else if (f_ready) begin
            f_valid <= 1'b0;
        end
    end

`ifdef MUX_RR_PARITY_EN
    // Parity travels with f and uses the same load/hold rules.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            f_par <= 1'b0;
        else if (xfer)
            f_par <= ^gnt_data;
    end
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: a vector table plus hand-written sequences on an N=4
// instance and an N=3 instance, followed by a random run checked against a
// queue-free reference model.
module tb_mux_nx1_rr;

    logic        clk;
    logic        rst;

    logic [31:0] x4;
    logic [3:0]  xv4, xr4;
    logic        mode4, fv4, frdy4;
    logic [1:0]  s4, fch4;
    logic [7:0]  f4;
    logic        fpar4;

    logic [23:0] x3;
    logic [2:0]  xv3, xr3;
    logic        mode3, fv3, frdy3;
    logic [1:0]  s3, fch3;
    logic [7:0]  f3;
    logic        fpar3;

    int checks = 0;
    int failures = 0;

    mux_nx1_rr #(.N(4), .W(8)) u4 (
        .clk(clk), .rst(rst), .x(x4), .x_valid(xv4), .x_ready(xr4),
        .mode(mode4), .s(s4), .f(f4), .f_ch(fch4), .f_valid(fv4),
`ifdef MUX_RR_PARITY_EN
        .f_par(fpar4),
`endif
        .f_ready(frdy4)
    );

    mux_nx1_rr #(.N(3), .W(8)) u3 (
        .clk(clk), .rst(rst), .x(x3), .x_valid(xv3), .x_ready(xr3),
        .mode(mode3), .s(s3), .f(f3), .f_ch(fch3), .f_valid(fv3),
`ifdef MUX_RR_PARITY_EN
        .f_par(fpar3),
`endif
        .f_ready(frdy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Spec-level grant rule: returns -1 when there is no grant.
    function automatic int ref_grant(input int n, input logic md, input int sel,
                                     input logic [15:0] v, input int p);
        if (!md) begin
            if (sel < n && v[sel]) return sel;
            return -1;
        end
        for (int k = 0; k < n; k++)
            if (v[(p + k) % n]) return (p + k) % n;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] s;
        logic [3:0] xv;
        logic       frdy;
        logic [3:0] xr;
        logic       fv;
        logic [7:0] f;
        logic [1:0] ch;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int          mptr, g;
        logic [7:0]  mf;
        logic [1:0]  mch;
        logic        mfv, mld;
        logic [3:0]  exr;
        logic [2:0]  exp3 [4];
        logic [1:0]  ech3 [4];

        // Channel words for the N=4 table: ch0=10 ch1=21 ch2=A5 ch3=3C
        tbl.push_back('{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2});
        tbl.push_back('{1'b0, 2'd3, 4'b0100, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2});
        tbl.push_back('{1'b0, 2'd1, 4'b0011, 1'b0, 4'b0010, 1'b1, 8'h21, 2'd1});
        tbl.push_back('{1'b0, 2'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 8'h21, 2'd1});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3});
        tbl.push_back('{1'b1, 2'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd3});
        tbl.push_back('{1'b1, 2'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd3});
        tbl.push_back('{1'b1, 2'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd3});
        tbl.push_back('{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1});
        tbl.push_back('{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
        tbl.push_back('{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0});

        rst = 1'b1;
        x4 = 32'h3CA5_2110; xv4 = 4'b1111; mode4 = 1'b1; s4 = 2'd0; frdy4 = 1'b1;
        x3 = 24'h33_2211;   xv3 = 3'b000;  mode3 = 1'b1; s3 = 2'd0; frdy3 = 1'b1;

        // Reset with every channel valid
        @(posedge clk); #1;
        chk("rst_x_ready", xr4, 4'b0000);
        chk("rst_f", f4, 8'h00);
        chk("rst_f_ch", fch4, 2'd0);
        chk("rst_f_valid", fv4, 1'b0);
        rst = 1'b0;
        #2 chk("rel_x_ready", xr4, 4'b0001);
        @(posedge clk); #1;
        chk("rel_f_valid", fv4, 1'b1);
        chk("rel_f_ch", fch4, 2'd0);

        // Vector table
        do_reset();
        foreach (tbl[i]) begin
            mode4 = tbl[i].mode; s4 = tbl[i].s; xv4 = tbl[i].xv; frdy4 = tbl[i].frdy;
            #2 chk($sformatf("tbl%0d_x_ready", i), xr4, tbl[i].xr);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_f_valid", i), fv4, tbl[i].fv);
            chk($sformatf("tbl%0d_f", i), f4, tbl[i].f);
            chk($sformatf("tbl%0d_f_ch", i), fch4, tbl[i].ch);
        end
        xv4 = 4'b0000;

        // N=3 wrap: move ptr to 2, then alternate between ch2 and ch0
        mode3 = 1'b1; xv3 = 3'b010; frdy3 = 1'b1;
        #2 chk("n3_prime_x_ready", xr3, 3'b010);
        @(posedge clk); #1;
        chk("n3_prime_f_ch", fch3, 2'd1);
        exp3 = '{3'b100, 3'b001, 3'b100, 3'b001};
        ech3 = '{2'd2, 2'd0, 2'd2, 2'd0};
        xv3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            #2 chk($sformatf("n3_wrap%0d_x_ready", i), xr3, exp3[i]);
            @(posedge clk); #1;
            chk($sformatf("n3_wrap%0d_f_ch", i), fch3, ech3[i]);
            chk($sformatf("n3_wrap%0d_f", i), f3, (ech3[i] == 2'd2) ? 8'h33 : 8'h11);
            chk($sformatf("n3_wrap%0d_f_valid", i), fv3, 1'b1);
        end
        mode3 = 1'b0; s3 = 2'd3; xv3 = 3'b111;
        for (int i = 0; i < 2; i++) begin
            #2 chk($sformatf("n3_s3_%0d_x_ready", i), xr3, 3'b000);
            @(posedge clk); #1;
            chk($sformatf("n3_s3_%0d_f_valid", i), fv3, 1'b0);
        end
        xv3 = 3'b000;

        // Random run against the reference model
        do_reset();
        mptr = 0; mf = 8'h00; mch = 2'd0; mfv = 1'b0;
        for (int c = 0; c < 400; c++) begin
            mode4 = ($urandom_range(0, 3) != 0);
            s4    = 2'($urandom_range(0, 3));
            xv4   = 4'($urandom);
            frdy4 = ($urandom_range(0, 2) != 0);
            x4    = $urandom;
            mld   = !mfv || frdy4;
            g     = ref_grant(4, mode4, int'(s4), {12'h0, xv4}, mptr);
            exr   = (mld && g >= 0) ? 4'(1 << g) : 4'b0000;
            #2 chk("rand_x_ready", xr4, exr);
            @(posedge clk); #1;
            if (mld && g >= 0) begin
                mf  = x4[g*8 +: 8];
                mch = 2'(g);
                mfv = 1'b1;
                if (mode4) mptr = (g + 1) % 4;
            end else if (frdy4) begin
                mfv = 1'b0;
            end
            chk("rand_f_valid", fv4, mfv);
            chk("rand_f", f4, mf);
            chk("rand_f_ch", fch4, mch);
`ifdef MUX_RR_PARITY_EN
            chk("rand_f_par", fpar4, ^mf);
`endif
        end

        // Mid-stream reset drops the held beat and clears ptr
        do_reset();
        x4 = 32'h3CA5_2110; mode4 = 1'b1; xv4 = 4'b0001; frdy4 = 1'b0;
        @(posedge clk); #1;
        chk("mid_pre_f_valid", fv4, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_f", f4, 8'h00);
        chk("mid_f_ch", fch4, 2'd0);
        chk("mid_f_valid", fv4, 1'b0);
        chk("mid_x_ready", xr4, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0; xv4 = 4'b1111; frdy4 = 1'b1;
        #2 chk("mid_ptr_x_ready", xr4, 4'b0001);
        @(posedge clk); #1;

`ifdef MUX_RR_PARITY_EN
        do_reset();
        mode4 = 1'b0; s4 = 2'd0; xv4 = 4'b0001; frdy4 = 1'b1; x4 = 32'h0000_0007;
        @(posedge clk); #1;
        chk("par_07", fpar4, 1'b1);
        x4 = 32'h0000_0003;
        @(posedge clk); #1;
        chk("par_03", fpar4, 1'b0);
        x4 = 32'h0000_0007; frdy4 = 1'b0;
        @(posedge clk); #1;
        chk("par_hold", fpar4, 1'b0);
        chk("par_hold_f", f4, 8'h03);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised N-channel, W-bit sequential multiplexer, generalising the gate-level 4:1 bit mux.
- Selects one input channel per cycle into a registered output stage with valid/ready handshake.
- Two modes: fixed select (external sel, like classic mux) and round-robin scan across valid channels.
- Used as the channel-merge stage ahead of shared datapath logic.

Parameters:
- N, 4, number of input channels (2..16, need not be power of two)
- W, 8, data width per channel
- SEL_W, $clog2(N), localparam, select/channel-index width (not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- x  input  N*W  flattened channel data; channel i = x[i*W +: W]
- x_valid  input  N  per-channel data valid
- x_ready  output  N  per-channel accept; combinational, one-hot or zero
- mode  input  1  0 = fixed select, 1 = round-robin
- s  input  SEL_W  channel select, used only when mode=0
- f  output  W  registered selected data
- f_ch  output  SEL_W  registered index of channel that produced f
- f_valid  output  1  f/f_ch hold valid data
- f_ready  input  1  downstream accept

Behaviour:
- Reset (async, rst=1): f=0, f_ch=0, f_valid=0, rr pointer ptr=0; x_ready=0 while rst high.
- Load enable: ld = !f_valid || f_ready. Output stage accepts at most one beat per cycle.
- Grant selection (combinational):
  - mode=0: grant = s if s<N and x_valid[s]; else no grant. s>=N never grants.
  - mode=1: grant = first i with x_valid[i], searching ptr, ptr+1, ..., wrapping modulo N (not modulo 2^SEL_W); no grant if x_valid=0.
- x_ready[grant]=1 only when a grant exists and ld=1; all other bits 0.
- Transfer on a channel: x_valid[i] && x_ready[i] at clk edge.
- On transfer: f<=data of grant, f_ch<=grant, f_valid<=1; in mode=1, ptr<=(grant==N-1)?0:grant+1.
- No transfer and f_valid && f_ready: f_valid<=0; f, f_ch hold last values.
- No transfer and f_valid && !f_ready: all output registers hold (stall); x_ready=0.
- Simultaneous pop and push (f_valid && f_ready && grant): new beat loaded same cycle, f_valid stays 1; full throughput 1 beat/cycle.
- Latency: 1 cycle from transfer to f_valid.
- ptr updates only on transfers in mode=1; mode=0 leaves ptr unchanged. Switching mode mid-stream takes effect next grant; registered beat unaffected.
- f and f_ch do not change while f_valid && !f_ready.
- rst asserted mid-stream: in-flight beat dropped, all state to reset values immediately.

Optional Feature:
- Macro MUX_RR_PARITY_EN.
- Defined: extra output f_par (1 bit, registered with f, reset 0) = even parity (XOR reduction) of the loaded data word; follows the same hold/load rules as f.
- Not defined: port f_par absent; no parity logic.

Test Plan:
- Reset: rst=1 with x_valid=all ones -> f=0, f_ch=0, f_valid=0, x_ready=0; release -> first grant next cycle.
- Fixed select: N=4, W=8, mode=0, s=2, x ch2=0xA5, x_valid=4'b0100, f_ready=1 -> x_ready=4'b0100, next cycle f=0xA5, f_ch=2, f_valid=1; s=3 with x_valid[3]=0 -> no grant, f_valid falls to 0.
- Round-robin fairness: mode=1, x_valid=4'b1111, f_ready=1 held 8 cycles -> f_ch sequence 0,1,2,3,0,1,2,3, one beat per cycle.
- Backpressure: f_valid=1, f_ready=0 for 3 cycles with x_valid=4'b0011 -> x_ready=0, f/f_ch/ptr constant; f_ready=1 -> next channel granted same cycle, no beat lost or duplicated.
- Non-power-of-two wrap: N=3, mode=1, x_valid=3'b101, ptr=2 -> grants 2,0,2,0; mode=0 s=3 -> never grants.
- Parity (MUX_RR_PARITY_EN): load 0x07 -> f_par=1; load 0x03 -> f_par=0; stall holds f_par.
